// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types, opcodes and immediate decode for multi_cycle_cpu
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_S,
    IMM_B
  } imm_fmt_e;

  function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default: imm = {{20{ir[31]}}, ir[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - REG_COUNT x XLEN register file, 2 async reads, 1 sync write, x0 hardwired to zero
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] wd_i
);

  localparam int IDX_W = $clog2(REG_COUNT);

  logic [XLEN-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && rd_i != 5'd0 && int'(rd_i) < REG_COUNT) begin
      regs_q[rd_i[IDX_W-1:0]] <= wd_i;
    end
  end

  // Out-of-range indices are trapped as illegal in decode; reading zero here just keeps them harmless.
  assign rd1_o = (rs1_i != 5'd0 && int'(rs1_i) < REG_COUNT) ? regs_q[rs1_i[IDX_W-1:0]] : '0;
  assign rd2_o = (rs2_i != 5'd0 && int'(rs2_i) < REG_COUNT) ? regs_q[rs2_i[IDX_W-1:0]] : '0;

endmodule

// File: rtl/multi_cycle_cpu.sv
// rtl/multi_cycle_cpu.sv - RV32I-subset multi-cycle core with handshaked instruction/data memories
// Optional CPU_PERF_CNT_EN adds cycle_cnt_o and instret_o counters.
module multi_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              REG_COUNT = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_ack_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            retire_o,
  output logic            halt_o,
  output logic [XLEN-1:0] pc_o
`ifdef CPU_PERF_CNT_EN
  ,
  output logic [63:0]     cycle_cnt_o,
  output logic [63:0]     instret_o
`endif
);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] a_q, b_q, imm_q, alu_q, mdr_q;
  logic            imem_req_q, dmem_req_q, dmem_we_q, halt_q;
  logic [XLEN-1:0] dmem_addr_q, dmem_wdata_q;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  alu_op_e  alu_op;
  imm_fmt_e imm_fmt;
  logic     illegal, uses_rd, uses_rs2;

  always_comb begin
    alu_op   = ALU_ADD;
    imm_fmt  = IMM_I;
    illegal  = 1'b0;
    uses_rd  = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        uses_rd  = 1'b1;
        uses_rs2 = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: alu_op = ALU_ADD;
          {7'b0100000, 3'b000}: alu_op = ALU_SUB;
          {7'b0000000, 3'b111}: alu_op = ALU_AND;
          {7'b0000000, 3'b110}: alu_op = ALU_OR;
          {7'b0000000, 3'b010}: alu_op = ALU_SLT;
          default:              illegal = 1'b1;
        endcase
      end
      OP_I: begin
        uses_rd = 1'b1;
        illegal = (funct3 != 3'b000);
      end
      OP_LW: begin
        uses_rd = 1'b1;
        illegal = (funct3 != 3'b010);
      end
      OP_SW: begin
        uses_rs2 = 1'b1;
        imm_fmt  = IMM_S;
        illegal  = (funct3 != 3'b010);
      end
      OP_BEQ: begin
        uses_rs2 = 1'b1;
        imm_fmt  = IMM_B;
        illegal  = (funct3 != 3'b000);
      end
      default: illegal = 1'b1;
    endcase
    if (int'(rs1) >= REG_COUNT || (uses_rs2 && int'(rs2) >= REG_COUNT) ||
        (uses_rd && int'(rd) >= REG_COUNT)) begin
      illegal = 1'b1;
    end
  end

  logic [XLEN-1:0] imm_x;
  assign imm_x = XLEN'($signed(imm_gen(ir_q, imm_fmt)));

  logic [XLEN-1:0] rf_rd1, rf_rd2;

  cpu_regfile #(
    .XLEN      (XLEN),
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rs1_i (rs1),
    .rs2_i (rs2),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2),
    .we_i  (state_q == S_WB),
    .rd_i  (rd),
    .wd_i  ((opcode == OP_LW) ? mdr_q : alu_q)
  );

  logic [XLEN-1:0] alu_b, alu_res, pc_plus4, br_target;
  logic            br_taken, br_misaligned;

  assign alu_b = (opcode == OP_R) ? b_q : imm_q;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_SUB: alu_res = a_q - alu_b;
      ALU_AND: alu_res = a_q & alu_b;
      ALU_OR:  alu_res = a_q | alu_b;
      ALU_SLT: alu_res = XLEN'($signed(a_q) < $signed(alu_b));
      default: alu_res = a_q + alu_b;
    endcase
  end

  assign pc_plus4      = pc_q + XLEN'(4);
  assign br_target     = pc_q + imm_q;
  assign br_taken      = (a_q == b_q);
  assign br_misaligned = br_taken && (br_target[1:0] != 2'b00);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      alu_q        <= '0;
      mdr_q        <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      halt_q       <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          // After reset the request rises one cycle late, so an ack left over from before reset is never taken.
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (imem_ack_i) begin
            ir_q       <= imem_rdata_i;
            imem_req_q <= 1'b0;
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (illegal) begin
            halt_q  <= 1'b1;
            state_q <= S_HALT;
          end else begin
            a_q     <= rf_rd1;
            b_q     <= rf_rd2;
            imm_q   <= imm_x;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_q <= alu_res;
          if (opcode == OP_BEQ) begin
            if (br_misaligned) begin
              halt_q  <= 1'b1;
              state_q <= S_HALT;
            end else begin
              pc_q       <= br_taken ? br_target : pc_plus4;
              imem_req_q <= 1'b1;
              state_q    <= S_FETCH;
            end
          end else if (opcode == OP_LW || opcode == OP_SW) begin
            if (alu_res[1:0] != 2'b00) begin
              halt_q  <= 1'b1;
              state_q <= S_HALT;
            end else begin
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= (opcode == OP_SW);
              dmem_addr_q  <= alu_res;
              dmem_wdata_q <= b_q;
              state_q      <= S_MEM;
            end
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack_i) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (dmem_we_q) begin
              pc_q       <= pc_plus4;
              imem_req_q <= 1'b1;
              state_q    <= S_FETCH;
            end else begin
              mdr_q   <= dmem_rdata_i;
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          pc_q       <= pc_plus4;
          imem_req_q <= 1'b1;
          state_q    <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Stores retire on the ack itself, so the strobe has to be decoded from state and handshake.
  assign retire_o = !rst_i &&
                    ((state_q == S_WB) ||
                     (state_q == S_MEM && dmem_we_q && dmem_ack_i) ||
                     (state_q == S_EXEC && opcode == OP_BEQ && !br_misaligned));

  assign imem_req_o   = imem_req_q;
  assign imem_addr_o  = pc_q;
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign halt_o       = halt_q;
  assign pc_o         = pc_q;

`ifdef CPU_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, instret_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 64'd1;
      if (retire_o) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instret_o   = instret_q;
`endif

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb/tb_multi_cycle_cpu.sv - directed self-checking bench for multi_cycle_cpu with wait-state memory models
module tb_multi_cycle_cpu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o, imem_ack_i, dmem_req_o, dmem_we_o, dmem_ack_i, retire_o, halt_o;
  logic [31:0] imem_addr_o, imem_rdata_i, dmem_addr_o, dmem_wdata_o, dmem_rdata_i, pc_o;
`ifdef CPU_PERF_CNT_EN
  logic [63:0] cycle_cnt_o, instret_o;
  logic [63:0] perf_cyc12, perf_inst13;
`endif

  always #5 clk_i = ~clk_i;

  multi_cycle_cpu dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .retire_o     (retire_o),
    .halt_o       (halt_o),
    .pc_o         (pc_o)
`ifdef CPU_PERF_CNT_EN
    ,
    .cycle_cnt_o  (cycle_cnt_o),
    .instret_o    (instret_o)
`endif
  );

  logic [31:0] imem [32];
  logic [31:0] dmem [16];
  int   imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0;
  logic imem_manual = 1'b0, imem_ack_man = 1'b0;

  assign imem_ack_i   = imem_manual ? imem_ack_man : (imem_req_o && icnt == imem_wait);
  assign imem_rdata_i = imem[imem_addr_o[6:2]];
  assign dmem_ack_i   = dmem_req_o && dcnt == dmem_wait;
  assign dmem_rdata_i = dmem[dmem_addr_o[5:2]];

  always @(posedge clk_i) begin
    icnt <= (rst_i || !imem_req_o || imem_ack_i) ? 0 : icnt + 1;
    dcnt <= (rst_i || !dmem_req_o || dmem_ack_i) ? 0 : dcnt + 1;
    if (!rst_i && dmem_req_o && dmem_ack_i && dmem_we_o) dmem[dmem_addr_o[5:2]] <= dmem_wdata_o;
  end

  // Observation log, cleared whenever reset is seen; cycle 0 is the first cycle after reset.
  int          cyc, unstable, halt_cycles, halt_bad, dreq_cycles;
  int          ret_q[$];
  logic [31:0] st_addr_q[$], st_data_q[$];
  logic [31:0] pc_hist [256];
  logic        prev_dreq, prev_ireq;
  logic [31:0] p_daddr, p_dwdata, p_iaddr, halt_pc;
  logic        p_dwe;

  always @(negedge clk_i) begin
    if (rst_i) begin
      cyc = 0; unstable = 0; halt_cycles = 0; halt_bad = 0; dreq_cycles = 0;
      ret_q.delete(); st_addr_q.delete(); st_data_q.delete();
      prev_dreq = 1'b0; prev_ireq = 1'b0;
    end else begin
      if (cyc < 256) pc_hist[cyc] = pc_o;
      if (retire_o) ret_q.push_back(cyc);
      if (dmem_req_o && dmem_ack_i && dmem_we_o) begin
        st_addr_q.push_back(dmem_addr_o);
        st_data_q.push_back(dmem_wdata_o);
      end
      if (dmem_req_o) dreq_cycles++;
      if (prev_dreq && (!dmem_req_o || dmem_addr_o != p_daddr || dmem_wdata_o != p_dwdata || dmem_we_o != p_dwe))
        unstable++;
      if (prev_ireq && (!imem_req_o || imem_addr_o != p_iaddr)) unstable++;
      prev_dreq = dmem_req_o && !dmem_ack_i;
      p_daddr = dmem_addr_o; p_dwdata = dmem_wdata_o; p_dwe = dmem_we_o;
      prev_ireq = imem_req_o && !imem_ack_i && !imem_manual;
      p_iaddr = imem_addr_o;
      if (halt_o) begin
        if (halt_cycles == 0) halt_pc = pc_o;
        halt_cycles++;
        if (imem_req_o || dmem_req_o || retire_o || pc_o != halt_pc) halt_bad++;
      end
`ifdef CPU_PERF_CNT_EN
      if (cyc == 12) perf_cyc12 = cycle_cnt_o;
      if (cyc == 13) perf_inst13 = instret_o;
`endif
      cyc++;
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] qget32(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) imem[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string name);
    int n = 0;
    while (!halt_o && n < budget) begin
      @(negedge clk_i); #1;
      n++;
    end
    check({name, "_halt_reached"}, {31'b0, halt_o}, 32'd1);
  endtask

  task automatic wait_retires(input int cnt, input int budget, input string name);
    int n = 0;
    while (ret_q.size() < cnt && n < budget) begin
      @(negedge clk_i); #1;
      n++;
    end
    check({name, "_retire_count"}, 32'(ret_q.size() >= cnt), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [11:0] i1, i2;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [9];

  initial begin
    vecs[0] = '{"add",       12'd5,   12'd7,   7'h00, 3'b000, 32'd12};
    vecs[1] = '{"sub_neg",   12'd5,   12'd7,   7'h20, 3'b000, 32'hFFFF_FFFE};
    vecs[2] = '{"and",       12'h0F0, 12'h0FF, 7'h00, 3'b111, 32'h0000_00F0};
    vecs[3] = '{"or",        12'h0F0, 12'h00F, 7'h00, 3'b110, 32'h0000_00FF};
    vecs[4] = '{"slt_true",  12'hFFF, 12'h001, 7'h00, 3'b010, 32'd1};
    vecs[5] = '{"slt_false", 12'h001, 12'hFFF, 7'h00, 3'b010, 32'd0};
    vecs[6] = '{"slt_min",   12'h800, 12'h7FF, 7'h00, 3'b010, 32'd1};
    vecs[7] = '{"sub_big",   12'h800, 12'h7FF, 7'h20, 3'b000, 32'hFFFF_F001};
    vecs[8] = '{"add_wrap",  12'hFFF, 12'h001, 7'h00, 3'b000, 32'd0};

    // Tests 1 and 2: straight-line arithmetic, then store/load with three data wait-states.
    clear_mem();
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h0070_0113;
    imem[2] = 32'h0020_81B3;
    imem[3] = enc_s(12'd8, 5'd3, 5'd0);
    imem[4] = enc_i(12'd8, 5'd0, 3'b010, 5'd4, 7'b0000011);
    imem[5] = enc_s(12'd12, 5'd4, 5'd0);
    dmem_wait = 3;
    do_reset();
    @(negedge clk_i); #1;
    check("reset_pc", pc_o, 32'd0);
    check("reset_ctrl", {27'b0, imem_req_o, dmem_req_o, dmem_we_o, retire_o, halt_o}, 32'd0);
    check("reset_daddr", dmem_addr_o, 32'd0);
    check("reset_wdata", dmem_wdata_o, 32'd0);
    wait_halt(200, "t1");
    check("t1_retire0_cycle", qget(ret_q, 0), 32'd4);
    check("t1_retire1_cycle", qget(ret_q, 1), 32'd8);
    check("t1_retire2_cycle", qget(ret_q, 2), 32'd12);
    check("t1_pc_after", pc_hist[13], 32'd12);
    check("t2_sw_addr", qget32(st_addr_q, 0), 32'd8);
    check("t2_sw_data_x3", qget32(st_data_q, 0), 32'd12);
    check("t2_lw_latency", qget(ret_q, 4) - qget(ret_q, 3), 32'd8);
    check("t2_lw_value_x4", qget32(st_data_q, 1), 32'd12);
    check("t2_req_stable", unstable, 32'd0);
    check("t2_total_retires", ret_q.size(), 32'd6);
`ifdef CPU_PERF_CNT_EN
    check("perf_cycle_cnt", perf_cyc12[31:0], 32'd12);
    check("perf_instret", perf_inst13[31:0], 32'd3);
`endif
    dmem_wait = 0;

    // Table-driven ALU vectors: two addi operands, one R-type, store result to address 0.
    for (int v = 0; v < 9; v++) begin
      clear_mem();
      imem[0] = addi(5'd1, 5'd0, vecs[v].i1);
      imem[1] = addi(5'd2, 5'd0, vecs[v].i2);
      imem[2] = enc_r(vecs[v].f7, 5'd2, 5'd1, vecs[v].f3, 5'd3);
      imem[3] = enc_s(12'd0, 5'd3, 5'd0);
      imem_wait = v % 2;
      do_reset();
      wait_halt(200, vecs[v].name);
      check({vecs[v].name, "_result"}, qget32(st_data_q, 0), vecs[v].exp);
    end
    imem_wait = 0;

    // Test 3: taken backward branch and not-taken branch, both at PC=16.
    for (int t = 0; t < 2; t++) begin
      clear_mem();
      imem[0] = addi(5'd1, 5'd0, 12'd5);
      imem[1] = addi(5'd2, 5'd0, 12'd7);
      imem[2] = addi(5'd0, 5'd0, 12'd0);
      imem[3] = addi(5'd0, 5'd0, 12'd0);
      imem[4] = (t == 0) ? enc_b(13'h1FF8, 5'd1, 5'd1) : enc_b(13'd8, 5'd2, 5'd1);
      do_reset();
      wait_retires(5, 100, t == 0 ? "beq_taken" : "beq_not_taken");
      repeat (2) @(negedge clk_i);
      #1;
      check(t == 0 ? "beq_taken_latency" : "beq_nt_latency", qget(ret_q, 4) - qget(ret_q, 3), 32'd3);
      check(t == 0 ? "beq_taken_old_pc" : "beq_nt_old_pc", pc_hist[qget(ret_q, 4) & 255], 32'd16);
      check(t == 0 ? "beq_taken_new_pc" : "beq_nt_new_pc", pc_hist[(qget(ret_q, 4) + 1) & 255],
            t == 0 ? 32'd8 : 32'd20);
    end

    // Test 4: illegal instruction, then misaligned load; both must freeze the core.
    clear_mem();
    do_reset();
    wait_halt(50, "illegal");
    repeat (22) @(negedge clk_i);
    #1;
    check("illegal_halt_cycles", 32'(halt_cycles >= 20), 32'd1);
    check("illegal_frozen", halt_bad, 32'd0);
    check("illegal_no_retire", ret_q.size(), 32'd0);
    check("illegal_pc", pc_o, 32'd0);

    clear_mem();
    imem[0] = addi(5'd1, 5'd0, 12'd6);
    imem[1] = enc_i(12'd0, 5'd1, 3'b010, 5'd2, 7'b0000011);
    do_reset();
    wait_halt(50, "misaligned");
    repeat (22) @(negedge clk_i);
    #1;
    check("misaligned_halt_cycles", 32'(halt_cycles >= 20), 32'd1);
    check("misaligned_frozen", halt_bad, 32'd0);
    check("misaligned_retires", ret_q.size(), 32'd1);
    check("misaligned_no_dmem", dreq_cycles, 32'd0);
    check("misaligned_pc", pc_o, 32'd4);

    // Test 5: reset during a fetch wait, stale ack arrives in the first cycle after reset.
    clear_mem();
    imem[0] = addi(5'd1, 5'd0, 12'd5);
    imem_manual  = 1'b1;
    imem_ack_man = 1'b0;
    do_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("t5_fetch_waiting", {31'b0, imem_req_o}, 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    imem_ack_man = 1'b1;
    @(negedge clk_i);
    check("t5_req_dropped", {31'b0, imem_req_o}, 32'd0);
    check("t5_pc_reset", pc_o, 32'd0);
    @(posedge clk_i);
    #1;
    imem_ack_man = 1'b0;
    imem_manual  = 1'b0;
    @(negedge clk_i);
    check("t5_fetch_restarts", {31'b0, imem_req_o}, 32'd1);
    wait_retires(1, 50, "t5");
    check("t5_first_retire_cycle", qget(ret_q, 0), 32'd4);

    // Test 6: writes to x0 are discarded.
    clear_mem();
    imem[0] = addi(5'd0, 5'd0, 12'd9);
    imem[1] = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd5);
    imem[2] = enc_s(12'd4, 5'd5, 5'd0);
    do_reset();
    wait_halt(100, "x0");
    check("x0_store_addr", qget32(st_addr_q, 0), 32'd4);
    check("x0_x5_value", qget32(st_data_q, 0), 32'd0);
    check("x0_retires", ret_q.size(), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
